// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
//   Shared widths, requester indices and mode encodings for the D_ram port
//   arbiter, plus a helper that steps a requester index round the ring
//   Rx -> Tx -> P -> Rx.
//   Optional feature macro used by the arbiter: DRAM_ARB_ROUND_ROBIN_EN.
package dram_arb_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_RX = 2'd0;
  localparam logic [1:0] REQ_TX = 2'd1;
  localparam logic [1:0] REQ_P  = 2'd2;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RX   = 2'd1,
    MODE_PROC = 2'd2,
    MODE_TX   = 2'd3
  } mode_e;

  // Next requester in ring order Rx -> Tx -> P -> Rx.
  function automatic logic [1:0] next_req(input logic [1:0] idx);
    return (idx == REQ_P) ? REQ_RX : idx + 2'd1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_pick.sv
// arb_pick
//   Combinational winner selection over the 3-bit candidate mask
//   (bit 0 Rx, bit 1 Tx, bit 2 P).
//   DRAM_ARB_ROUND_ROBIN_EN defined  : rotating priority starting at ptr.
//   DRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority P > Rx > Tx.
// Ports:
//   mask   in  3 : candidates after eligibility and burst exclusion
//   ptr    in  2 : highest-priority requester (round-robin build only)
//   valid  out 1 : some candidate won
//   idx    out 2 : winner index
//   onehot out 3 : winner as one-hot, zero when no winner
module arb_pick
  import dram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
`ifdef DRAM_ARB_ROUND_ROBIN_EN
  input  logic [1:0]         ptr,
`endif
  output logic               valid,
  output logic [1:0]         idx,
  output logic [NUM_REQ-1:0] onehot
);

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] cand1;
  logic [1:0] cand2;

  assign cand1 = next_req(ptr);
  assign cand2 = next_req(cand1);

  always_comb begin
    idx = ptr;
    if (mask[ptr])        idx = ptr;
    else if (mask[cand1]) idx = cand1;
    else if (mask[cand2]) idx = cand2;
  end
`else
  always_comb begin
    idx = REQ_P;
    if (mask[REQ_P])       idx = REQ_P;
    else if (mask[REQ_RX]) idx = REQ_RX;
    else if (mask[REQ_TX]) idx = REQ_TX;
  end
`endif

  assign valid  = |mask;
  assign onehot = valid ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares the single D_ram port among the Rx writer, the Tx data retriever
//   and the processor. One registered grant per access cycle; read data comes
//   back in rdata one cycle after the grant with the matching rvalid pulse.
//   Optional feature macro: DRAM_ARB_ROUND_ROBIN_EN (rotating priority);
//   default build uses fixed priority P > Rx > Tx.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   mode                      : 0 IDLE (nobody eligible), 1..3 all eligible
//   rx_req/tx_req/p_req       : level requests; req high through gnt = next beat
//   rx_addr/tx_addr/p_addr    : request addresses
//   rx_din/p_din, p_wen       : write data, processor write select
//   rx_gnt/tx_gnt/p_gnt       : one-hot access-cycle pulse
//   tx_rvalid/p_rvalid, rdata : read return, one cycle after the grant
//   ram_addr/ram_din/ram_wen  : D_ram port (RAM samples on the falling edge)
//   ram_q                     : D_ram read data
// Handshake: a request seen high at rising edge N is granted in cycle N+1;
// the requester drops req during its gnt cycle to stop, otherwise the same
// request competes again. Read data is valid only while *_rvalid is high and
// rdata then holds until the next read completes.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              rx_req,
  input  logic              tx_req,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] rx_din,
  input  logic [DATA_W-1:0] p_din,
  input  logic              p_wen,
  output logic              rx_gnt,
  output logic              tx_gnt,
  output logic              p_gnt,
  output logic              tx_rvalid,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic [NUM_REQ-1:0] gnt_q;      // registered winner, one-hot (access cycle)
  logic [3:0]         burst_cnt;  // consecutive grants to the gnt_q owner
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] cand;
  logic               excl;
  logic               win_valid;
  logic [1:0]         win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_write;
  logic               rd_done;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
`endif

  assign req_vec = {p_req, tx_req, rx_req};
  assign elig    = (mode != MODE_IDLE) ? req_vec : '0;

  // The current owner sits out one arbitration once it has used its burst
  // allowance, but only if somebody else is actually waiting.
  assign excl = (burst_cnt >= MAX_B) && (|(elig & ~gnt_q));
  assign cand = excl ? (elig & ~gnt_q) : elig;

  arb_pick u_pick (
    .mask   (cand),
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    .ptr    (rr_ptr),
`endif
    .valid  (win_valid),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  assign win_write = win_valid &&
                     ((win_idx == REQ_RX) || ((win_idx == REQ_P) && p_wen));

  // The access in flight is a read when Tx owns it, or P owns it without wen.
  assign rd_done = gnt_q[REQ_TX] | (gnt_q[REQ_P] & ~ram_wen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= '0;
      burst_cnt <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_wen   <= 1'b0;
      tx_rvalid <= 1'b0;
      p_rvalid  <= 1'b0;
      rdata     <= '0;
    end else begin
      gnt_q   <= win_onehot;
      ram_wen <= win_write;

      if (!win_valid)                burst_cnt <= '0;
      else if (win_onehot == gnt_q) begin
        if (burst_cnt != 4'hF)       burst_cnt <= burst_cnt + 4'd1;
      end else                       burst_cnt <= 4'd1;

      // Port address/data are captured with the grant so they are stable for
      // the whole access cycle; without a grant they hold their last values.
      if (win_valid) begin
        case (win_idx)
          REQ_RX: begin
            ram_addr <= rx_addr;
            ram_din  <= rx_din;
          end
          REQ_TX: ram_addr <= tx_addr;
          default: begin
            ram_addr <= p_addr;
            ram_din  <= p_din;
          end
        endcase
      end

      tx_rvalid <= gnt_q[REQ_TX];
      p_rvalid  <= gnt_q[REQ_P] & ~ram_wen;
      if (rd_done) rdata <= ram_q;
    end
  end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  // After a grant the winner drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= REQ_RX;
    else if (win_valid) rr_ptr <= next_req(win_idx);
  end
`endif

  assign rx_gnt = gnt_q[REQ_RX];
  assign tx_gnt = gnt_q[REQ_TX];
  assign p_gnt  = gnt_q[REQ_P];

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//   Self-checking bench for dram_port_arbiter with a negedge RAM model.
//   Honors DRAM_ARB_ROUND_ROBIN_EN for the expected arbitration order.
module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode;
  logic        rx_req, tx_req, p_req;
  logic [17:0] rx_addr, tx_addr, p_addr;
  logic [7:0]  rx_din, p_din;
  logic        p_wen;
  logic        rx_gnt, tx_gnt, p_gnt, tx_rvalid, p_rvalid;
  logic [7:0]  rdata;
  logic [17:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_wen;
  logic [7:0]  ram_q;
  logic [2:0]  gnt_v;

  assign gnt_v = {p_gnt, tx_gnt, rx_gnt};

  dram_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .rx_req(rx_req), .tx_req(tx_req), .p_req(p_req),
    .rx_addr(rx_addr), .tx_addr(tx_addr), .p_addr(p_addr),
    .rx_din(rx_din), .p_din(p_din), .p_wen(p_wen),
    .rx_gnt(rx_gnt), .tx_gnt(tx_gnt), .p_gnt(p_gnt),
    .tx_rvalid(tx_rvalid), .p_rvalid(p_rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen),
    .ram_q(ram_q)
  );

  // D_ram model, falling-edge clocked, with a backdoor write path.
  bit [7:0]    ram [0:262143];
  logic        bd_we = 1'b0;
  logic [17:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(negedge clk) begin
    if (bd_we)        ram[bd_addr]  <= bd_data;
    else if (ram_wen) ram[ram_addr] <= ram_din;
    ram_q <= ram[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // reference model state
  int m_last = -1;
  int m_run  = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
  int m_ptr  = 0;
`endif
  bit [7:0] ref_mem [0:63];
  logic [2:0]  exp_gnt;
  logic        exp_wen, exp_tx_rv, exp_p_rv;
  logic [17:0] exp_addr;
  logic [7:0]  exp_din;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] req;       // {p, tx, rx}
    logic [2:0] exp_fixed; // expected {p,tx,rx} gnt, fixed priority
    logic [2:0] exp_rr;    // expected gnt, round robin from reset
  } vec_t;
  vec_t vt[8];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rx_req = 0; tx_req = 0; p_req = 0; p_wen = 0;
    rx_addr = '0; tx_addr = '0; p_addr = '0;
    rx_din = '0; p_din = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic bd_write(input logic [17:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1;
    @(negedge clk);
    #1;
    bd_we = 0;
  endtask

  task automatic p_read(input logic [17:0] a, input logic [7:0] exp, input string tag);
    p_addr = a; p_wen = 0; p_req = 1;
    tick();
    chk({tag, " p_gnt"}, gnt_v, 3'b100);
    chk({tag, " ram_addr"}, ram_addr, a);
    chk({tag, " ram_wen"}, ram_wen, 0);
    p_req = 0;
    tick();
    chk({tag, " p_rvalid"}, p_rvalid, 1);
    chk({tag, " rdata"}, rdata, exp);
    chk({tag, " no regrant"}, gnt_v, 3'b000);
  endtask

  // Reference arbitration: walk the priority order, skipping the current
  // owner when it has had MAXB grants in a row and someone else waits.
  function automatic int model_pick(input bit [2:0] r);
    int order[3];
    int others;
    bit skip_last;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) order[k] = (m_ptr + k) % 3;
`else
    order = '{2, 0, 1};
`endif
    others = 0;
    for (int k = 0; k < 3; k++) if (r[k] && k != m_last) others++;
    skip_last = (m_last >= 0) && (m_run >= MAXB) && (others > 0);
    for (int k = 0; k < 3; k++)
      if (r[order[k]] && !(skip_last && order[k] == m_last)) return order[k];
    return -1;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] expg, prevg;
    int beat;
    clear_inputs();
    mode = 2'd0;

    vt[0] = '{2'd0, 3'b111, 3'b000, 3'b000};
    vt[1] = '{2'd1, 3'b111, 3'b100, 3'b001};
    vt[2] = '{2'd2, 3'b011, 3'b001, 3'b001};
    vt[3] = '{2'd3, 3'b010, 3'b010, 3'b010};
    vt[4] = '{2'd2, 3'b110, 3'b100, 3'b010};
    vt[5] = '{2'd1, 3'b100, 3'b100, 3'b100};
    vt[6] = '{2'd3, 3'b000, 3'b000, 3'b000};
    vt[7] = '{2'd2, 3'b101, 3'b100, 3'b001};

    do_reset();
    // reset state
    chk("reset gnt", gnt_v, 0);
    chk("reset rvalid", {tx_rvalid, p_rvalid}, 0);
    chk("reset port", {ram_wen, ram_addr, ram_din}, 0);
    chk("reset rdata", rdata, 0);

    // table-driven single arbitrations from reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mode = vt[i].mode;
      {p_req, tx_req, rx_req} = vt[i].req;
      rx_addr = 18'h100; tx_addr = 18'h101; p_addr = 18'h102;
      rx_din = 8'h77; p_wen = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      expg = vt[i].exp_rr;
`else
      expg = vt[i].exp_fixed;
`endif
      tick();
      chk($sformatf("vec%0d gnt", i), gnt_v, expg);
      chk($sformatf("vec%0d wen", i), ram_wen, expg == 3'b001);
      rx_req = 0; tx_req = 0; p_req = 0;
      tick();
      chk($sformatf("vec%0d single", i), gnt_v, 0);
    end

    // single read
    bd_write(18'd16, 8'hA5);
    bd_write(18'd5, 8'h5A);
    bd_write(18'd6, 8'h6B);
    do_reset();
    mode = 2'd2;
    p_read(18'h00010, 8'hA5, "single");

    // concurrent reads, P and Tx held high
    do_reset();
    mode = 2'd2;
    p_addr = 18'd5; tx_addr = 18'd6; p_req = 1; tx_req = 1;
    prevg = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      expg = (i % 2 == 0) ? 3'b010 : 3'b100;
`else
      expg = (i % 5 == 4) ? 3'b010 : 3'b100;
`endif
      chk($sformatf("conc gnt%0d", i), gnt_v, expg);
      chk($sformatf("conc rv%0d", i), {p_rvalid, tx_rvalid}, {prevg[2], prevg[1]});
      if (prevg != 0) chk($sformatf("conc rdata%0d", i), rdata, prevg[2] ? 8'h5A : 8'h6B);
      prevg = expg;
    end
    p_req = 0; tx_req = 0;
    tick();
    chk("conc last rv", {p_rvalid, tx_rvalid}, {prevg[2], prevg[1]});

    // IDLE mask
    do_reset();
    mode = 2'd0;
    rx_req = 1; tx_req = 1; p_req = 1; p_wen = 1;
    rx_addr = 18'h200; tx_addr = 18'h201; p_addr = 18'h202;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle gnt%0d", i), gnt_v, 0);
      chk($sformatf("idle wen%0d", i), ram_wen, 0);
    end
    mode = 2'd1;
    tick();
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    chk("idle->rx first gnt", gnt_v, 3'b001);
`else
    chk("idle->rx first gnt", gnt_v, 3'b100);
`endif
    rx_req = 0; tx_req = 0; p_req = 0; p_wen = 0;
    tick();
    tick();

    // Rx stream, 4 beats, address advanced in each gnt cycle
    do_reset();
    mode = 2'd1;
    rx_req = 1; rx_addr = 18'd0; rx_din = 8'h11;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (beat < 4) begin
        chk($sformatf("rx beat%0d gnt", beat), gnt_v, 3'b001);
        chk($sformatf("rx beat%0d wen", beat), ram_wen, 1);
        chk($sformatf("rx beat%0d addr", beat), ram_addr, beat);
        chk($sformatf("rx beat%0d din", beat), ram_din, 8'(8'h11 * (beat + 1)));
        beat++;
        if (beat == 4) rx_req = 0;
        else begin
          rx_addr = 18'(beat);
          rx_din  = 8'(8'h11 * (beat + 1));
        end
      end else begin
        chk($sformatf("rx after c%0d", c), {gnt_v, ram_wen}, 0);
      end
    end
    for (int a = 0; a < 4; a++) p_read(18'(a), 8'(8'h11 * (a + 1)), $sformatf("rx readback%0d", a));

    // reset during the gnt cycle of a read
    do_reset();
    mode = 2'd2;
    p_addr = 18'd16; p_wen = 0; p_req = 1;
    tick();
    chk("rstmid gnt", gnt_v, 3'b100);
    rst = 1;
    #1;
    chk("rstmid flags", {gnt_v, tx_rvalid, p_rvalid, ram_wen}, 0);
    chk("rstmid addr", ram_addr, 0);
    chk("rstmid din/rdata", {ram_din, rdata}, 0);
    p_req = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid quiet%0d", i), {gnt_v, p_rvalid, tx_rvalid}, 0);
    end
    p_read(18'd16, 8'hA5, "rstmid next");

    // randomized traffic against the reference model
    for (int a = 0; a < 64; a++) begin
      ref_mem[a] = 8'(a * 37 + 11);
      bd_write(18'(a), 8'(a * 37 + 11));
    end
    do_reset();
    mode = 2'd2;
    exp_gnt = 0; exp_wen = 0; exp_tx_rv = 0; exp_p_rv = 0;
    exp_addr = '0; exp_din = '0;
    m_last = -1; m_run = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    m_ptr = 0;
`endif
    exp_q.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      int w;
      bit [2:0] r;
      logic [17:0] wa;
      logic nx_tx_rv, nx_p_rv;
      // requester behaviour: new address/data only when idle or just granted
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if (!rx_req || exp_gnt[0]) begin
        rx_addr = 18'($urandom_range(0, 63)); rx_din = 8'($urandom_range(0, 255));
      end
      if (!tx_req || exp_gnt[1]) tx_addr = 18'($urandom_range(0, 63));
      if (!p_req || exp_gnt[2]) begin
        p_addr = 18'($urandom_range(0, 63)); p_din = 8'($urandom_range(0, 255));
        p_wen = ($urandom_range(0, 1) == 1);
      end
      rx_req = ($urandom_range(0, 9) < 5);
      tx_req = ($urandom_range(0, 9) < 6);
      p_req  = ($urandom_range(0, 9) < 7);

      // model: the access now in flight returns data next cycle if a read
      nx_tx_rv = exp_gnt[1];
      nx_p_rv  = exp_gnt[2] && !exp_wen;
      r = (mode != 2'd0) ? {p_req, tx_req, rx_req} : 3'b000;
      w = model_pick(r);
      if (w < 0) begin
        exp_gnt = 0; exp_wen = 0;
        m_last = -1; m_run = 0;
      end else begin
        wa = (w == 0) ? rx_addr : (w == 1) ? tx_addr : p_addr;
        exp_gnt = 3'(1 << w);
        exp_addr = wa;
        exp_wen = (w == 0) || (w == 2 && p_wen);
        if (exp_wen) begin
          exp_din = (w == 0) ? rx_din : p_din;
          ref_mem[wa[5:0]] = exp_din;
        end else begin
          exp_q.push_back(ref_mem[wa[5:0]]);
        end
        m_run = (w == m_last) ? m_run + 1 : 1;
        m_last = w;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        m_ptr = (w + 1) % 3;
`endif
      end
      exp_tx_rv = nx_tx_rv;
      exp_p_rv  = nx_p_rv;

      tick();
      chk($sformatf("rnd%0d gnt", cyc), gnt_v, exp_gnt);
      chk($sformatf("rnd%0d wen", cyc), ram_wen, exp_wen);
      chk($sformatf("rnd%0d addr", cyc), ram_addr, exp_addr);
      if (exp_wen) chk($sformatf("rnd%0d din", cyc), ram_din, exp_din);
      chk($sformatf("rnd%0d rvalid", cyc), {tx_rvalid, p_rvalid}, {exp_tx_rv, exp_p_rv});
      if (tx_rvalid || p_rvalid) begin
        if (exp_q.size() == 0) chk($sformatf("rnd%0d unexpected read", cyc), 1, 0);
        else chk($sformatf("rnd%0d rdata", cyc), rdata, exp_q.pop_front());
      end
    end
    clear_inputs();
    tick();
    tick();
    chk("rnd reads drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
